// File: rtl/mmio_data_memory.sv
// mmio_data_memory
// ----------------
// Data memory on the CPU load/store path. The CPU byte address is decoded
// into a word RAM region and a 16-byte memory-mapped I/O block. The I/O
// block holds synchronised push-button levels with sticky rise flags, a
// free-running timer and a 32-bit Galois LFSR random source.
//
// I/O register map (word offset from IO_BASE):
//   0 BTN_LEVEL  RO   synchronised button levels, zero-extended
//   1 BTN_EDGE   R/W1C sticky rise flags, zero-extended
//   2 TIMER      R/W  free-running counter, write loads
//   3 RAND       R/W  LFSR state, write loads (0 reloads the seed)
//
// Ports:
//   clk      in   CPU clock, all state updates on the rising edge
//   rst      in   synchronous active-high reset (RAM is not cleared)
//   we       in   CPU write enable
//   a        in   byte address, a[1:0] ignored
//   wd       in   write data
//   rd       out  read data, combinational from a and current state
//   btn_in   in   asynchronous raw button levels, active-high
//   rand_out out  current LFSR value
module mmio_data_memory #(
   parameter int                DATA_W    = 32,
   parameter int                RAM_DEPTH = 256,
   parameter logic [31:0]       RAM_BASE  = 32'h0000_0000,
   parameter logic [31:0]       IO_BASE   = 32'h0000_1000,
   parameter int                N_BTN     = 4,
   parameter logic [DATA_W-1:0] LFSR_SEED = 32'hACE1_2024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [31:0]       a,
   input  logic [DATA_W-1:0] wd,
   output logic [DATA_W-1:0] rd,
   input  logic [N_BTN-1:0]  btn_in,
   output logic [DATA_W-1:0] rand_out
);

   localparam int                IDX_W     = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
   localparam logic [31:0]       RAM_BYTES = 32'(4 * RAM_DEPTH);
   localparam logic [DATA_W-1:0] LFSR_MASK = DATA_W'(32'h8020_0003);

   localparam logic [1:0] OFF_LEVEL = 2'd0;
   localparam logic [1:0] OFF_EDGE  = 2'd1;
   localparam logic [1:0] OFF_TIMER = 2'd2;
   localparam logic [1:0] OFF_RAND  = 2'd3;

   // ---------------- address decode ----------------
   logic [31:0]      ram_off;
   logic [31:0]      io_off;
   logic             ram_hit;
   logic             io_hit;
   logic [IDX_W-1:0] ram_idx;
   logic [1:0]       io_sel;

   // Offsets wrap below the base, so a single unsigned upper-bound
   // compare also rejects addresses under the base.
   assign ram_off = a - RAM_BASE;
   assign io_off  = a - IO_BASE;
   assign ram_hit = (ram_off < RAM_BYTES);
   assign io_hit  = (io_off < 32'd16);
   assign ram_idx = ram_off[IDX_W+1:2];
   assign io_sel  = io_off[3:2];

   logic io_wr_edge;
   logic io_wr_timer;
   logic io_wr_rand;

   assign io_wr_edge  = we && io_hit && (io_sel == OFF_EDGE);
   assign io_wr_timer = we && io_hit && (io_sel == OFF_TIMER);
   assign io_wr_rand  = we && io_hit && (io_sel == OFF_RAND);

   // ---------------- RAM ----------------
   logic [DATA_W-1:0] mem [RAM_DEPTH];

   // No reset: RAM keeps its contents, and writes during reset still land.
   always_ff @(posedge clk) begin
      if (we && ram_hit) begin
         mem[ram_idx] <= wd;
      end
   end

   // ---------------- buttons ----------------
   logic [N_BTN-1:0] sync1_reg;
   logic [N_BTN-1:0] sync2_reg;
   logic [N_BTN-1:0] sync3_reg;
   logic [N_BTN-1:0] btn_edge_reg;
   logic [N_BTN-1:0] btn_edge_next;
   logic [N_BTN-1:0] rise;

   genvar gi;
   generate
      for (gi = 0; gi < N_BTN; gi++) begin : g_btn
         assign rise[gi] = sync2_reg[gi] & ~sync3_reg[gi];
         // Set is OR-ed in after the clear so a simultaneous rise wins.
         assign btn_edge_next[gi] = rise[gi] |
                                    (btn_edge_reg[gi] & ~(io_wr_edge & wd[gi]));
      end
   endgenerate

   // ---------------- timer and LFSR ----------------
   logic [DATA_W-1:0] timer_reg;
   logic [DATA_W-1:0] timer_next;
   logic [DATA_W-1:0] lfsr_reg;
   logic [DATA_W-1:0] lfsr_next;
   logic [DATA_W-1:0] lfsr_step;

   assign lfsr_step = {1'b0, lfsr_reg[DATA_W-1:1]} ^ (lfsr_reg[0] ? LFSR_MASK : '0);

   always_comb begin
      timer_next = timer_reg + 1'b1;
      if (io_wr_timer) begin
         timer_next = wd;
      end
      lfsr_next = lfsr_step;
      if (io_wr_rand) begin
         // All-zero is the LFSR's lock-up state, so reseed instead.
         lfsr_next = (wd == '0) ? LFSR_SEED : wd;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_reg    <= '0;
         sync2_reg    <= '0;
         sync3_reg    <= '0;
         btn_edge_reg <= '0;
         timer_reg    <= '0;
         lfsr_reg     <= LFSR_SEED;
      end else begin
         sync1_reg    <= btn_in;
         sync2_reg    <= sync1_reg;
         sync3_reg    <= sync2_reg;
         btn_edge_reg <= btn_edge_next;
         timer_reg    <= timer_next;
         lfsr_reg     <= lfsr_next;
      end
   end

   assign rand_out = lfsr_reg;

   // ---------------- read mux ----------------
   logic [DATA_W-1:0] level_ext;
   logic [DATA_W-1:0] edge_ext;

   always_comb begin
      level_ext              = '0;
      level_ext[N_BTN-1:0]   = sync2_reg;
      edge_ext               = '0;
      edge_ext[N_BTN-1:0]    = btn_edge_reg;
      rd                     = '0;
      if (ram_hit) begin
         rd = mem[ram_idx];
      end else if (io_hit) begin
         case (io_sel)
            OFF_LEVEL: rd = level_ext;
            OFF_EDGE:  rd = edge_ext;
            OFF_TIMER: rd = timer_reg;
            default:   rd = lfsr_reg;
         endcase
      end
   end

endmodule
